// File: rtl/cpu_types_pkg.sv
// Shared processor types: the machine word and the instruction-cache FSM states.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: one synchronous write port, one asynchronous read port.
// Only the valid bits are cleared by reset; tag and data come up undefined.
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS  = 16,
  parameter int unsigned IDX_W = $clog2(SETS),
  parameter int unsigned TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_wen,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [TAG_W-1:0] i_wtag,
  input  word_t            i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic             o_rvalid,
  output logic [TAG_W-1:0] o_rtag,
  output word_t            o_rdata
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            data;
  } frame_t;

  frame_t r_frames [SETS];

  // A fill overwrites the whole frame; reset only has to invalidate.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < int'(SETS); i++) begin
        r_frames[i].valid <= 1'b0;
      end
    end else if (i_wen) begin
      r_frames[i_widx] <= '{valid: 1'b1, tag: i_wtag, data: i_wdata};
    end
  end

  assign o_rvalid = r_frames[i_ridx].valid;
  assign o_rtag   = r_frames[i_ridx].tag;
  assign o_rdata  = r_frames[i_ridx].data;

endmodule

// File: rtl/icache_responder.sv
// Read-only direct-mapped instruction cache responder: zero-latency hits,
// single-word refill from the memory controller on a miss.
module icache_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  icache_state_t    r_state;
  logic             r_iren;
  word_t            r_iaddr;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_rvalid;
  logic [TAG_W-1:0] w_rtag;
  word_t            w_rdata;
  logic             w_hit;
  logic             w_fill;
  logic             w_unused;

  assign w_idx    = imemaddr[IDX_W+1:2];
  assign w_tag    = imemaddr[31:IDX_W+2];
  assign w_unused = &{1'b0, imemaddr[1:0]};

  // Hits are only answered from IDLE and never while reset is asserted.
  assign w_hit = nRST & imemREN & w_rvalid & (w_rtag == w_tag) & (r_state == IDLE);
  assign w_fill = (r_state == FETCH) & ~iwait;

  assign ihit     = w_hit;
  assign imemload = w_hit ? w_rdata : '0;
  assign iREN     = r_iren;
  assign iaddr    = r_iaddr;

  icache_frame_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_frames (
    .CLK      (CLK),
    .nRST     (nRST),
    .i_wen    (w_fill),
    .i_widx   (r_iaddr[IDX_W+1:2]),
    .i_wtag   (r_iaddr[31:IDX_W+2]),
    .i_wdata  (iload),
    .i_ridx   (w_idx),
    .o_rvalid (w_rvalid),
    .o_rtag   (w_rtag),
    .o_rdata  (w_rdata)
  );

  // The memory read always runs to completion on the latched address.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_iren  <= 1'b0;
      r_iaddr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (imemREN && !w_hit) begin
            r_state <= FETCH;
            r_iren  <= 1'b1;
            r_iaddr <= {imemaddr[31:2], 2'b00};
          end else begin
            r_iren  <= 1'b0;
          end
        end
        FETCH: begin
          if (!iwait) begin
            r_state <= IDLE;
            r_iren  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_iren  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: memory model with a scoreboard of
// expected fetch addresses, a hit-vector table, and hand-written miss sequences.
module tb_icache_responder;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  int checks = 0;
  int errors = 0;

  word_t exp_q[$];
  int    wait_cfg = 0;
  int    wcnt     = 0;
  bit    in_fetch = 1'b0;

  typedef struct {
    logic  ren;
    word_t addr;
    logic  exp_hit;
    word_t exp_data;
  } vec_t;

  vec_t vecs[$];

  icache_responder #(.SETS(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  always #5 CLK = ~CLK;

  function automatic word_t mem_word(input word_t a);
    case (a)
      32'h0000_0004: return 32'h2401_000A;
      32'h0000_0044: return 32'h8D29_0000;
      default:       return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  task automatic chk(input string nm, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Memory controller model: wait_cfg busy cycles, then data for the requested word.
  task automatic mem_respond();
    word_t e;
    if (iREN === 1'b1) begin
      if (!in_fetch) begin
        in_fetch = 1'b1;
        wcnt = wait_cfg;
        if (exp_q.size() == 0) begin
          chk("unexpected_fetch", iaddr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("fetch_addr", iaddr, e);
        end
      end
      if (wcnt > 0) begin
        iwait = 1'b1;
        iload = 32'h0;
        wcnt--;
      end else begin
        iwait = 1'b0;
        iload = mem_word(iaddr);
      end
    end else begin
      in_fetch = 1'b0;
      iwait = 1'b0;
      iload = 32'h0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    mem_respond();
    #1;
  endtask

  // Miss on a, check zero-hit request cycle, latency, fetch length and returned word.
  task automatic miss_fill(input word_t a, input int waits, input string nm);
    int n = 0;
    int nren = 0;
    bit got = 1'b0;
    wait_cfg = waits;
    exp_q.push_back({a[31:2], 2'b00});
    imemREN = 1'b1;
    imemaddr = a;
    #1;
    chk({nm, "_miss_ihit"}, 32'(ihit), 32'd0);
    while (!got && n < 64) begin
      tick();
      n++;
      if (iREN) nren++;
      if (ihit) got = 1'b1;
    end
    chk({nm, "_got_hit"}, 32'(got), 32'd1);
    chk({nm, "_latency"}, 32'(n), 32'(waits + 2));
    chk({nm, "_iren_cycles"}, 32'(nren), 32'(waits + 1));
    chk({nm, "_data"}, imemload, mem_word({a[31:2], 2'b00}));
  endtask

  initial begin
    int n;
    bit got;
    nRST = 1'b0;
    imemREN = 1'b1;
    imemaddr = 32'h4;
    iwait = 1'b0;
    iload = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_iren", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
    nRST = 1'b1;

    // Cold miss: 3 busy cycles, then 0x2401000A
    miss_fill(32'h4, 3, "cold");

    // Hit table after the fill
    for (int i = 0; i < 5; i++) vecs.push_back('{1'b1, 32'h4, 1'b1, 32'h2401_000A});
    vecs.push_back('{1'b1, 32'h6, 1'b1, 32'h2401_000A});
    vecs.push_back('{1'b1, 32'h7, 1'b1, 32'h2401_000A});
    vecs.push_back('{1'b0, 32'h4, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h44, 1'b0, 32'h0});
    foreach (vecs[i]) begin
      imemREN = vecs[i].ren;
      imemaddr = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d_ihit", i), 32'(ihit), 32'(vecs[i].exp_hit));
      chk($sformatf("vec%0d_data", i), imemload, vecs[i].exp_data);
      chk($sformatf("vec%0d_iren", i), 32'(iREN), 32'd0);
      tick();
    end

    // Conflict miss on idx 1, then original line misses again
    miss_fill(32'h44, 1, "conflict");
    miss_fill(32'h4, 0, "refetch");

    // Address change mid-FETCH: 0x10 still fills, then 0x20 is fetched
    wait_cfg = 4;
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h20);
    imemREN = 1'b1;
    imemaddr = 32'h10;
    n = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      tick();
      n++;
      if (n == 2) begin
        imemaddr = 32'h20;
        #1;
        chk("chg_iaddr_held", iaddr, 32'h10);
        chk("chg_ihit_fetch", 32'(ihit), 32'd0);
      end
      if (ihit) got = 1'b1;
    end
    chk("chg_got_hit", 32'(got), 32'd1);
    chk("chg_data", imemload, mem_word(32'h20));
    chk("chg_q_empty", 32'(exp_q.size()), 32'd0);
    imemaddr = 32'h10;
    #1;
    chk("chg_old_hit", 32'(ihit), 32'd1);
    chk("chg_old_data", imemload, mem_word(32'h10));
    tick();
    chk("chg_old_no_iren", 32'(iREN), 32'd0);

    // Reset in the middle of a fetch
    wait_cfg = 5;
    exp_q.push_back(32'h30);
    imemREN = 1'b1;
    imemaddr = 32'h30;
    tick();
    tick();
    chk("rmid_in_fetch", 32'(iREN), 32'd1);
    nRST = 1'b0;
    tick();
    chk("rmid_iren", 32'(iREN), 32'd0);
    chk("rmid_ihit", 32'(ihit), 32'd0);
    imemREN = 1'b0;
    nRST = 1'b1;
    tick();
    chk("rmid_idle_iren", 32'(iREN), 32'd0);
    miss_fill(32'h4, 0, "post_rst");

    // imemREN low on a cached address: no hit, no request
    imemREN = 1'b0;
    imemaddr = 32'h4;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ren0_ihit", 32'(ihit), 32'd0);
      chk("ren0_iren", 32'(iREN), 32'd0);
    end
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
